fifo_burst_wr_ctrl: RTL and testbench
=====================================

// Module: fifo_burst_wr_ctrl
// PURPOSE
//  Write-side producer for the sync/async FIFO controller: takes a valid/ready/last stream in the wclk domain and drives the FIFO write port.
//  Admits data in bursts of up to c_BURST_LEN beats; a burst starts only when the FIFO reports enough free space for the whole burst.
//  Sits between upstream packet sources and the FIFO write interface (w_en, wfull, wr_water_level).
// PARAMETERS
//  c_DATA_WIDTH    32   stream/FIFO data width
//  c_DEPTH_WIDTH   8    FIFO write address width (depth = 2**c_DEPTH_WIDTH)
//  c_BURST_LEN     16   max beats per burst, 1..2**c_DEPTH_WIDTH-c_LAT_MARGIN
//  c_LAT_MARGIN    2    extra free entries required at burst start (covers water-level latency)
// PORTS
//  wclk                 in   1                write clock
//  wrst                 in   1                reset, asynchronous, active-high
//  s_valid              in   1                upstream beat valid
//  s_ready              out  1                upstream ready (registered)
//  s_data               in   c_DATA_WIDTH     upstream data
//  s_last               in   1                last beat of packet
//  fifo_w_en            out  1                FIFO write enable
//  fifo_wdata           out  c_DATA_WIDTH     FIFO write data
//  fifo_wfull           in   1                FIFO full flag (registered in FIFO controller)
//  fifo_wr_water_level  in   c_DEPTH_WIDTH+1  FIFO write-side fill level
//  burst_active         out  1                high while in BURST state
//  word_count           out  32               total words written, wraps at 2**32
//  ovf_err              out  1                sticky: fifo_wfull seen while a beat was pending in BURST
// BEHAVIOUR
//  Reset: s_ready=0, fifo_w_en=0, fifo_wdata=0, burst_active=0, word_count=0, ovf_err=0; skid empty, state IDLE, beat_cnt=0.
//  s_ready is 1 on the first wclk edge after wrst deasserts.
//  Skid buffer: 2 entries, push on s_valid&&s_ready; s_ready <= (occ_next < 2); never overflows, never drops a beat.
//  free = 2**c_DEPTH_WIDTH - fifo_wr_water_level (width c_DEPTH_WIDTH+1, no underflow: level <= depth).
//  FSM IDLE: occ>0 && free >= c_BURST_LEN+c_LAT_MARGIN -> BURST next cycle, beat_cnt=0. Otherwise stay.
//  FSM BURST: pop = occ>0 && !fifo_wfull; fifo_w_en = pop (combinational), fifo_wdata = skid head (combinational, 0 when occ=0).
//   On pop: beat_cnt++, word_count++. Exit to IDLE after the pop where beat_cnt==c_BURST_LEN-1 or head.last==1.
//   occ==0 in BURST: stall in BURST, w_en=0 (burst stays open until BURST_LEN or last).
//   fifo_wfull && occ>0: no write, head held, ovf_err<=1 (sticky until wrst); resume same beat when wfull drops.
//  At least one IDLE cycle between consecutive bursts (admission re-evaluated from fresh water level).
//  Push and pop in the same cycle: occ unchanged, order preserved.
//  wrst mid-burst: all state to reset values immediately; buffered beats discarded.
//  burst_active = (state==BURST), registered.
// STRUCTURE
//  Shared package: state encoding (IDLE, BURST), free-space width function of c_DEPTH_WIDTH.
//  Sub-module fifo_wr_skid_buf: 2-entry {last,data} buffer with registered ready, push/pop, occ, head outputs.
//  Top: admission compare, FSM, beat_cnt, word_count, ovf_err.
// TESTING
//  Reset: hold wrst 5 cycles -> all outputs 0; s_ready=1 one cycle after release.
//  Empty FIFO, 32 continuous beats, s_last on beat 32 -> two 16-beat write bursts, exactly 1 idle cycle between, word_count=32.
//  Level=239 (free 17) -> no fifo_w_en; level=238 (free 18) -> burst_active 1 next cycle.
//  s_last on beat 5 of a burst -> 5 writes, IDLE next cycle, next packet starts a new burst.
//  Force fifo_wfull for 3 cycles mid-burst -> w_en 0, fifo_wdata stable, ovf_err=1 sticky; data order intact after release.
//  Assert wrst after beat 7 of a burst -> w_en 0 immediately, word_count=0, skid empty, FSM IDLE.

Source files
------------

// File: rtl/fifo_burst_wr_ctrl_pkg.sv
// Shared types and helpers for the FIFO burst write controller.
package fifo_burst_wr_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wr_state_e;

    // Free-space count must hold the full depth, so it needs one bit more than the address.
    function automatic int unsigned free_width(input int unsigned depth_width);
        return depth_width + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_skid_buf.sv
// Two-entry {last,data} skid buffer with registered ready.
module fifo_wr_skid_buf
    import fifo_burst_wr_ctrl_pkg::*;
#(
    parameter int unsigned c_DATA_WIDTH = 32
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [c_DATA_WIDTH-1:0] s_data,
    input  logic                    s_last,
    input  logic                    pop,
    output logic [1:0]              occ,
    output logic [c_DATA_WIDTH-1:0] head_data,
    output logic                    head_last
);

    localparam int unsigned c_ENTRY_W = c_DATA_WIDTH + 1;

    logic [c_ENTRY_W-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 push;
    logic [1:0]           occ_next;

    assign push = s_valid && s_ready;
    assign {head_last, head_data} = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 2'd1;
        end else if (pop && !push) begin
            occ_next = occ - 2'd1;
        end
    end

    // Storage, pointers and registered ready; reset discards any buffered beats.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
            s_ready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {s_last, s_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ     <= occ_next;
            s_ready <= (occ_next < 2'd2);
        end
    end

endmodule

// File: rtl/fifo_burst_wr_ctrl.sv
// Write-side burst producer: admits skid-buffered stream beats into the FIFO in space-checked bursts.
module fifo_burst_wr_ctrl
    import fifo_burst_wr_ctrl_pkg::*;
#(
    parameter int unsigned c_DATA_WIDTH  = 32,
    parameter int unsigned c_DEPTH_WIDTH = 8,
    parameter int unsigned c_BURST_LEN   = 16,
    parameter int unsigned c_LAT_MARGIN  = 2
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [c_DATA_WIDTH-1:0]  s_data,
    input  logic                     s_last,
    output logic                     fifo_w_en,
    output logic [c_DATA_WIDTH-1:0]  fifo_wdata,
    input  logic                     fifo_wfull,
    input  logic [c_DEPTH_WIDTH:0]   fifo_wr_water_level,
    output logic                     burst_active,
    output logic [31:0]              word_count,
    output logic                     ovf_err
);

    localparam int unsigned c_FREE_W = free_width(c_DEPTH_WIDTH);
    localparam int unsigned c_BCNT_W = $clog2(c_BURST_LEN + 1);
    localparam logic [c_FREE_W-1:0] c_DEPTH    = c_FREE_W'(2 ** c_DEPTH_WIDTH);
    localparam logic [c_FREE_W-1:0] c_ADMIT    = c_FREE_W'(c_BURST_LEN + c_LAT_MARGIN);
    localparam logic [c_BCNT_W-1:0] c_LAST_CNT = c_BCNT_W'(c_BURST_LEN - 1);

    wr_state_e                state;
    wr_state_e                state_next;
    logic [c_BCNT_W-1:0]      beat_cnt;
    logic [1:0]               occ;
    logic [c_DATA_WIDTH-1:0]  head_data;
    logic                     head_last;
    logic                     pop;
    logic [c_FREE_W-1:0]      free;
    logic                     admit;

    fifo_wr_skid_buf #(
        .c_DATA_WIDTH (c_DATA_WIDTH)
    ) u_skid (
        .wclk      (wclk),
        .wrst      (wrst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign free  = c_DEPTH - fifo_wr_water_level;
    assign admit = (occ != 2'd0) && (free >= c_ADMIT);

    // State register.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and pop decision; a burst closes on its final beat or on a packet end.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (admit) begin
                    state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if ((occ != 2'd0) && !fifo_wfull) begin
                    pop = 1'b1;
                    if ((beat_cnt == c_LAST_CNT) || head_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Beat counter within a burst, total word counter and sticky overflow flag.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            beat_cnt   <= '0;
            word_count <= 32'd0;
            ovf_err    <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + c_BCNT_W'(1);
            end
            if (pop) begin
                word_count <= word_count + 32'd1;
            end
            if ((state == ST_BURST) && (occ != 2'd0) && fifo_wfull) begin
                ovf_err <= 1'b1;
            end
        end
    end

    assign fifo_w_en    = pop;
    assign fifo_wdata   = ((state == ST_BURST) && (occ != 2'd0)) ? head_data : '0;
    assign burst_active = (state == ST_BURST);

endmodule

// File: tb/tb_fifo_burst_wr_ctrl.sv
// Self-checking bench for fifo_burst_wr_ctrl with random data and a queue-based reference model.
module tb_fifo_burst_wr_ctrl;

    localparam int BURST = 16;
    localparam int DEPTH = 256;
    localparam int ADMIT = 18;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'd0;
    logic        s_last = 1'b0;
    logic        fifo_w_en;
    logic [31:0] fifo_wdata;
    logic        fifo_wfull = 1'b0;
    logic [8:0]  fifo_wr_water_level = 9'd0;
    logic        burst_active;
    logic [31:0] word_count;
    logic        ovf_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit abort = 1'b0;

    logic [31:0] sent_d [$];
    bit          sent_l [$];
    logic [31:0] wr_d   [$];
    int          wr_c   [$];

    fifo_burst_wr_ctrl dut (
        .wclk                (wclk),
        .wrst                (wrst),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .s_data              (s_data),
        .s_last              (s_last),
        .fifo_w_en           (fifo_w_en),
        .fifo_wdata          (fifo_wdata),
        .fifo_wfull          (fifo_wfull),
        .fifo_wr_water_level (fifo_wr_water_level),
        .burst_active        (burst_active),
        .word_count          (word_count),
        .ovf_err             (ovf_err)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    // Log every FIFO write with the cycle it lands in.
    always @(negedge wclk) begin
        if (fifo_w_en) begin
            wr_d.push_back(fifo_wdata);
            wr_c.push_back(cyc);
        end
    end

    // Reference: write i opens a new burst if the previous burst hit BURST beats or ended on last.
    function automatic bit starts_burst(input int i);
        int k = 0;
        for (int j = 0; j < i; j++) begin
            k++;
            if (sent_l[j] || k == BURST) k = 0;
        end
        return (k == 0);
    endfunction

    task automatic apply_reset();
        wrst = 1'b1; s_valid = 1'b0; s_last = 1'b0; fifo_wfull = 1'b0; abort = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        wrst = 1'b0;
        sent_d.delete(); sent_l.delete(); wr_d.delete(); wr_c.delete();
        @(posedge wclk); #1;
    endtask

    task automatic send_pkt(input int n, input bit with_last);
        bit hs;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            s_last  = with_last && (i == n - 1);
            hs = 1'b0;
            for (int t = 0; t < 500 && !hs && !abort; t++) begin
                @(negedge wclk);
                if (s_ready) begin
                    hs = 1'b1;
                    sent_d.push_back(s_data);
                    sent_l.push_back(s_last);
                end
            end
            if (!hs) begin
                if (!abort) begin
                    total++; bad++;
                    $display("FAIL send_timeout: beat %0d not accepted, required handshake", i);
                end
                s_valid = 1'b0; s_last = 1'b0;
                return;
            end
            @(posedge wclk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int bound);
        for (int t = 0; t < bound; t++) begin
            if (wr_d.size() >= n) break;
            @(negedge wclk); #1;
        end
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        repeat (5) @(posedge wclk);
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b exp 0", s_ready); end
        total++; if (fifo_w_en !== 1'b0) begin bad++; $display("FAIL rst_w_en: got %b exp 0", fifo_w_en); end
        total++; if (fifo_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h exp 0", fifo_wdata); end
        total++; if (burst_active !== 1'b0) begin bad++; $display("FAIL rst_burst_active: got %b exp 0", burst_active); end
        total++; if (word_count !== 32'd0) begin bad++; $display("FAIL rst_word_count: got %0d exp 0", word_count); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL rst_ovf_err: got %b exp 0", ovf_err); end
        wrst = 1'b0;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rel_ready_early: got %b exp 0", s_ready); end
        @(posedge wclk); #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b exp 1", s_ready); end
    endtask

    task automatic test_two_bursts();
        apply_reset();
        fifo_wr_water_level = 9'd0;
        send_pkt(32, 1'b1);
        wait_writes(32, 200);
        total++; if (wr_d.size() != 32) begin bad++; $display("FAIL tb_count: got %0d exp 32", wr_d.size()); end
        for (int i = 0; i < 32 && i < wr_d.size(); i++) begin
            total++;
            if (wr_d[i] !== sent_d[i]) begin bad++; $display("FAIL tb_data[%0d]: got %h exp %h", i, wr_d[i], sent_d[i]); end
        end
        for (int i = 1; i < 32 && i < wr_c.size(); i++) begin
            total++;
            if (wr_c[i] - wr_c[i-1] != (starts_burst(i) ? 2 : 1)) begin
                bad++; $display("FAIL tb_gap[%0d]: got %0d exp %0d", i, wr_c[i] - wr_c[i-1], starts_burst(i) ? 2 : 1);
            end
        end
        repeat (2) @(posedge wclk);
        #1;
        total++; if (word_count !== 32'd32) begin bad++; $display("FAIL tb_word_count: got %0d exp 32", word_count); end
        total++; if (burst_active !== 1'b0) begin bad++; $display("FAIL tb_idle_after: got %b exp 0", burst_active); end
    endtask

    task automatic test_admission();
        bit exp_act;
        apply_reset();
        send_pkt(1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            fifo_wr_water_level = (k == 0) ? 9'd239 : 9'($urandom_range(DEPTH, 239));
            exp_act = ((DEPTH - int'(fifo_wr_water_level)) >= ADMIT);
            repeat (3) @(posedge wclk);
            #1;
            total++; if (burst_active !== exp_act) begin bad++; $display("FAIL adm_block lvl=%0d: got %b exp %b", fifo_wr_water_level, burst_active, exp_act); end
            total++; if (wr_d.size() != 0) begin bad++; $display("FAIL adm_no_write lvl=%0d: got %0d exp 0", fifo_wr_water_level, wr_d.size()); end
        end
        fifo_wr_water_level = 9'd238;
        @(posedge wclk); #1;
        total++; if (burst_active !== 1'b1) begin bad++; $display("FAIL adm_open: got %b exp 1", burst_active); end
        wait_writes(1, 20);
        total++; if (wr_d.size() != 1) begin bad++; $display("FAIL adm_count: got %0d exp 1", wr_d.size()); end
        if (wr_d.size() > 0) begin
            total++; if (wr_d[0] !== sent_d[0]) begin bad++; $display("FAIL adm_data: got %h exp %h", wr_d[0], sent_d[0]); end
        end
        @(posedge wclk); #1;
        total++; if (word_count !== 32'd1) begin bad++; $display("FAIL adm_word_count: got %0d exp 1", word_count); end
        fifo_wr_water_level = 9'd0;
    endtask

    task automatic test_short_packet();
        apply_reset();
        fifo_wr_water_level = 9'd0;
        send_pkt(5, 1'b1);
        send_pkt(4, 1'b1);
        wait_writes(9, 100);
        total++; if (wr_d.size() != 9) begin bad++; $display("FAIL sp_count: got %0d exp 9", wr_d.size()); end
        for (int i = 0; i < 9 && i < wr_d.size(); i++) begin
            total++;
            if (wr_d[i] !== sent_d[i]) begin bad++; $display("FAIL sp_data[%0d]: got %h exp %h", i, wr_d[i], sent_d[i]); end
        end
        for (int i = 1; i < 9 && i < wr_c.size(); i++) begin
            total++;
            if (wr_c[i] - wr_c[i-1] != (starts_burst(i) ? 2 : 1)) begin
                bad++; $display("FAIL sp_gap[%0d]: got %0d exp %0d", i, wr_c[i] - wr_c[i-1], starts_burst(i) ? 2 : 1);
            end
        end
        @(posedge wclk); #1;
        total++; if (word_count !== 32'd9) begin bad++; $display("FAIL sp_word_count: got %0d exp 9", word_count); end
    endtask

    task automatic test_wfull();
        apply_reset();
        fifo_wr_water_level = 9'd0;
        fork
            send_pkt(12, 1'b1);
            begin
                wait_writes(4, 100);
                @(posedge wclk); #1;
                total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL wf_ovf_pre: got %b exp 0", ovf_err); end
                fifo_wfull = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge wclk); #1;
                    total++; if (fifo_w_en !== 1'b0) begin bad++; $display("FAIL wf_w_en[%0d]: got %b exp 0", k, fifo_w_en); end
                    if (sent_d.size() > 4) begin
                        total++; if (fifo_wdata !== sent_d[4]) begin bad++; $display("FAIL wf_wdata[%0d]: got %h exp %h", k, fifo_wdata, sent_d[4]); end
                    end
                    @(posedge wclk); #1;
                end
                fifo_wfull = 1'b0;
                total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL wf_ovf_set: got %b exp 1", ovf_err); end
            end
        join
        wait_writes(12, 100);
        total++; if (wr_d.size() != 12) begin bad++; $display("FAIL wf_count: got %0d exp 12", wr_d.size()); end
        for (int i = 0; i < 12 && i < wr_d.size(); i++) begin
            total++;
            if (wr_d[i] !== sent_d[i]) begin bad++; $display("FAIL wf_data[%0d]: got %h exp %h", i, wr_d[i], sent_d[i]); end
        end
        repeat (4) @(posedge wclk);
        #1;
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL wf_ovf_sticky: got %b exp 1", ovf_err); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        fifo_wr_water_level = 9'd0;
        fork
            send_pkt(20, 1'b1);
            begin
                wait_writes(7, 100);
                @(posedge wclk); #1;
                wrst  = 1'b1;
                abort = 1'b1;
                #1;
                total++; if (fifo_w_en !== 1'b0) begin bad++; $display("FAIL mr_w_en: got %b exp 0", fifo_w_en); end
                total++; if (word_count !== 32'd0) begin bad++; $display("FAIL mr_word_count: got %0d exp 0", word_count); end
                total++; if (burst_active !== 1'b0) begin bad++; $display("FAIL mr_burst_active: got %b exp 0", burst_active); end
                total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mr_s_ready: got %b exp 0", s_ready); end
                total++; if (fifo_wdata !== 32'd0) begin bad++; $display("FAIL mr_wdata: got %h exp 0", fifo_wdata); end
            end
        join
        s_valid = 1'b0;
        total++; if (wr_d.size() != 7) begin bad++; $display("FAIL mr_pre_count: got %0d exp 7", wr_d.size()); end
        repeat (2) @(posedge wclk);
        #1;
        wrst = 1'b0;
        abort = 1'b0;
        repeat (12) @(posedge wclk);
        #1;
        total++; if (wr_d.size() != 7) begin bad++; $display("FAIL mr_skid_empty: got %0d writes exp 7", wr_d.size()); end
        total++; if (burst_active !== 1'b0) begin bad++; $display("FAIL mr_fsm_idle: got %b exp 0", burst_active); end
        sent_d.delete(); sent_l.delete(); wr_d.delete(); wr_c.delete();
        send_pkt(3, 1'b1);
        wait_writes(3, 50);
        total++; if (wr_d.size() != 3) begin bad++; $display("FAIL mr_new_count: got %0d exp 3", wr_d.size()); end
        for (int i = 0; i < 3 && i < wr_d.size(); i++) begin
            total++;
            if (wr_d[i] !== sent_d[i]) begin bad++; $display("FAIL mr_new_data[%0d]: got %h exp %h", i, wr_d[i], sent_d[i]); end
        end
        @(posedge wclk); #1;
        total++; if (word_count !== 32'd3) begin bad++; $display("FAIL mr_new_word_count: got %0d exp 3", word_count); end
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_admission();
        test_short_packet();
        test_wfull();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
